// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified IF/MA memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_MA = 1'b1
    } owner_t;

    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Counts BUSY cycles; expired_o flags the last allowed BUSY cycle.
module mem_arb_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    import mem_arb_pkg::*;

    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != CW'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds completed BUSY cycles, so TIMEOUT-1 marks the final one.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch (IF) and memory-access (MA) stages.
// Handshake: a requester holds its level request until its one-cycle done pulse, then drops it.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              ma_rd,
    input  logic              ma_wr,
    input  logic [ADDR_W-1:0] ma_addr,
    input  logic [DATA_W-1:0] ma_wdata,
    output logic [DATA_W-1:0] ma_rdata,
    output logic              ma_done,
    output logic              ma_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err,
    output logic [1:0]        dbg_state
);
    import mem_arb_pkg::*;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
    logic              wr_q, wr_d;
    logic              en_q, en_d;
    logic              if_done_q, if_done_d;
    logic              ma_done_q, ma_done_d;
    logic              err_q, err_d;
    logic              ma_req;
    logic              expired;

    assign ma_req = ma_rd | ma_wr;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_q != ST_BUSY),
        .en_i     (state_q == ST_BUSY),
        .expired_o(expired)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        en_d       = 1'b0;
        if_rdata_d = if_rdata_q;
        ma_rdata_d = ma_rdata_q;
        if_done_d  = 1'b0;
        ma_done_d  = 1'b0;
        err_d      = err_q | (ma_rd & ma_wr);
        case (state_q)
            ST_IDLE: begin
                if (mem_ready) err_d = 1'b1;
                // MA wins: it carries the older instruction in the pipeline.
                if (ma_req) begin
                    owner_d = OWN_MA;
                    addr_d  = ma_addr;
                    wdata_d = ma_wdata;
                    wr_d    = ma_wr;
                    en_d    = 1'b1;
                    state_d = ST_BUSY;
                end else if (if_req) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    wr_d    = 1'b0;
                    en_d    = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    if (!wr_q) begin
                        if (owner_q == OWN_MA) ma_rdata_d = mem_rdata;
                        else                   if_rdata_d = mem_rdata;
                    end
                    if (owner_q == OWN_MA) ma_done_d = 1'b1;
                    else                   if_done_d = 1'b1;
                    state_d = ST_RESP;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (mem_ready) err_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            en_q       <= 1'b0;
            if_rdata_q <= '0;
            ma_rdata_q <= '0;
            if_done_q  <= 1'b0;
            ma_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            en_q       <= en_d;
            if_rdata_q <= if_rdata_d;
            ma_rdata_q <= ma_rdata_d;
            if_done_q  <= if_done_d;
            ma_done_q  <= ma_done_d;
            err_q      <= err_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign ma_rdata  = ma_rdata_q;
    assign if_done   = if_done_q;
    assign ma_done   = ma_done_q;
    assign if_stall  = if_req & ~if_done_q;
    assign ma_stall  = ma_req & ~ma_done_q;
    assign mem_en    = en_q;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
